bus_fifo_slave: RTL and testbench
=================================

// Module: bus_fifo_slave
// PURPOSE
//  Bus responder: a FIFO slave that sits on one slave port (s0 or s1) of the 2-master bus.
//  Masters push 32-bit words by writing the DATA register and pop them by reading it.
//  Status, count and threshold registers are memory-mapped in the slave's 32-word window.
//  irq flags a fill level at or above a programmable threshold.
// PARAMETERS
//  DATA_WIDTH  32  width of s_din/s_dout and of each FIFO entry
//  DEPTH       8   FIFO entries; power of 2, 2..16
//  PTR_W       3   log2(DEPTH); the count register is PTR_W+1 bits
// PORTS
//  clk        in   1           rising-edge clock
//  reset_n    in   1           asynchronous active-low reset
//  s_sel      in   1           slave select from the bus address decoder
//  s_wr       in   1           1=write, 0=read; valid when s_sel=1
//  s_address  in   8           bus address; only [4:0] (offset) is used
//  s_din      in   DATA_WIDTH  write data from the granted master
//  s_dout     out  DATA_WIDTH  registered read data back to the bus
//  irq        out  1           count>=thresh && thresh!=0
// BEHAVIOUR
//  Reset (async, reset_n=0): rd_ptr=wr_ptr=count=0, ovf=udf=0, thresh=0, s_dout=0, irq=0.
//  Access rules:
//  - An access occurs only on a rising edge with s_sel=1.
//  - The bus delivers at most one access per cycle, so a push and a pop never coincide.
//  - When s_sel=0, no state changes and s_dout holds.
//  Register map (offset = s_address[4:0]):
//  - 0x00 DATA: W pushes, R pops.
//  - 0x01 STATUS: R = {28'b0, udf, ovf, full, empty}.
//  - 0x02 COUNT: R = count, zero-extended.
//  - 0x03 CTRL: W only; reads 0.
//  - 0x04 THRESH: R/W; low PTR_W+1 bits are stored.
//  - All other offsets: writes are ignored, reads return 0.
//  Write (s_sel&s_wr), taking effect at the same edge:
//  - DATA, not full: mem[wr_ptr]<=s_din; wr_ptr<=wr_ptr+1 (wraps mod DEPTH); count+1.
//  - DATA, full: data is dropped; pointers and count unchanged; ovf<=1 (sticky).
//  - CTRL bit0=1: flush, i.e. rd_ptr=wr_ptr=count=0. Memory contents are not cleared.
//  - CTRL bit1=1: ovf=udf=0. Both bits may be set in one write; both actions apply.
//  Read (s_sel&~s_wr), one-cycle latency:
//  - s_dout is loaded at the access edge and is valid the following cycle.
//    This matches the bus's registered read-data mux.
//  - DATA, not empty: s_dout<=mem[rd_ptr]; rd_ptr+1 (wraps); count-1.
//  - DATA, empty: s_dout<=0; pointers unchanged; udf<=1 (sticky).
//  - Reads of STATUS, COUNT and THRESH have no side effects.
//  Derived flags:
//  - empty = (count==0); full = (count==DEPTH).
//  - irq is combinational from the registers and updates the cycle after count or thresh changes.
//  - thresh > DEPTH is legal; irq then never asserts.
//  FIFO state machine:
//  - States are EMPTY (count 0), ACTIVE (0<count<DEPTH) and FULL (count DEPTH).
//  - A push moves EMPTY->ACTIVE and ACTIVE->FULL (or EMPTY->FULL when DEPTH would be 1, not allowed).
//  - A pop moves FULL->ACTIVE and ACTIVE->EMPTY.
//  - A flush moves any state to EMPTY.
//  - Errored accesses leave the state unchanged.
//  Reset mid-operation: all state clears immediately and the FIFO contents are discarded.
//  Back-to-back accesses: consecutive DATA reads pop once per cycle, in order.
// TESTING
//  1. Reset, then read STATUS -> s_dout=32'h1 (empty); COUNT=0; irq=0.
//  2. Write DATA 32'h11,22,33, then read DATA x3:
//     - s_dout = 11, 22, 33, each one cycle after its access;
//     - COUNT: 3, then 0 after the pops.
//  3. Write DATA x9 with DEPTH=8 -> COUNT=8, STATUS=32'h6 (ovf, full); 9th word is lost; pops return words 1..8.
//  4. Read DATA when empty -> s_dout=0, STATUS=32'h9; then write CTRL=2 -> STATUS=32'h1.
//  5. Write THRESH=3, push 2 -> irq=0; push 1 more -> irq=1 the next cycle; CTRL=1 (flush) -> irq=0, COUNT=0.
//  6. Wrap/reset: push 6, pop 6, push 5, pop 5 (pointers wrap) -> data in order.
//     Then push 2 and drop reset_n mid-cycle -> s_dout=0 and COUNT=0 immediately.

Source files
------------

// File: rtl/bus_fifo_slave.sv
// ---------------------------------------------------------------------------
// bus_fifo_slave
//   Memory-mapped FIFO responder for one slave port of the 2-master bus.
//   Masters push words by writing DATA and pop them by reading DATA; status,
//   fill count and an interrupt threshold live in the same 32-word window.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   s_sel      slave select from the bus address decoder
//   s_wr       1 = write, 0 = read (qualified by s_sel)
//   s_address  bus address; only the low five bits select a register
//   s_din      write data from the granted master
//   s_dout     registered read data, valid the cycle after the read access
//   irq        fill level at or above a non-zero threshold
//
// Register map (offset = s_address[4:0])
//   0x00 DATA    W push / R pop
//   0x01 STATUS  R {udf, ovf, full, empty} in bits [3:0]
//   0x02 COUNT   R fill level, zero-extended
//   0x03 CTRL    W bit0 flush, bit1 clear ovf/udf; reads 0
//   0x04 THRESH  R/W, low PTR_W+1 bits stored
// ---------------------------------------------------------------------------
module bus_fifo_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int PTR_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_sel,
  input  logic                  s_wr,
  input  logic [7:0]            s_address,
  input  logic [DATA_WIDTH-1:0] s_din,
  output logic [DATA_WIDTH-1:0] s_dout,
  output logic                  irq
);

  localparam logic [4:0] OFF_DATA   = 5'h00;
  localparam logic [4:0] OFF_STATUS = 5'h01;
  localparam logic [4:0] OFF_COUNT  = 5'h02;
  localparam logic [4:0] OFF_CTRL   = 5'h03;
  localparam logic [4:0] OFF_THRESH = 5'h04;

  localparam logic [PTR_W:0] CNT_ZERO = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0] CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
  // Fill level one below full: a push from here lands in FULL.
  localparam logic [PTR_W:0] CNT_LAST = CNT_FULL - CNT_ONE;

  localparam logic [PTR_W-1:0]      PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]      PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] WORD_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } fifo_state_e;

  // Storage and registers
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic [PTR_W:0]        thresh_q, thresh_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic [DATA_WIDTH-1:0] s_dout_q, s_dout_d;
  fifo_state_e           state_q, state_d;

  // Decoded access strobes
  logic [4:0] offset_s;
  logic       push_s;
  logic       pop_s;
  logic       flush_s;
  logic       empty_s;
  logic       full_s;
  logic       unused_addr_s;

  assign offset_s      = s_address[4:0];
  // Upper address bits are decoded by the bus, not here.
  assign unused_addr_s = ^s_address[7:5];

  // The FSM state is the single source for the empty/full flags so the
  // push/pop gating and the STATUS bits can never disagree.
  assign empty_s = (state_q == ST_EMPTY);
  assign full_s  = (state_q == ST_FULL);

  // Register decode: access side effects, read data and flag updates.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    thresh_d = thresh_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    s_dout_d = s_dout_q;
    push_s   = 1'b0;
    pop_s    = 1'b0;
    flush_s  = 1'b0;

    if (s_sel) begin
      if (s_wr) begin
        case (offset_s)
          OFF_DATA: begin
            if (full_s) begin
              ovf_d = 1'b1;
            end else begin
              push_s = 1'b1;
            end
          end
          OFF_CTRL: begin
            if (s_din[0]) begin
              flush_s = 1'b1;
            end else begin
              flush_s = 1'b0;
            end
            if (s_din[1]) begin
              ovf_d = 1'b0;
              udf_d = 1'b0;
            end else begin
              ovf_d = ovf_q;
              udf_d = udf_q;
            end
          end
          OFF_THRESH: begin
            thresh_d = s_din[PTR_W:0];
          end
          default: begin
            thresh_d = thresh_q;
          end
        endcase
      end else begin
        // Every read reloads s_dout; unmapped and write-only offsets read 0.
        s_dout_d = WORD_ZERO;
        case (offset_s)
          OFF_DATA: begin
            if (empty_s) begin
              udf_d = 1'b1;
            end else begin
              s_dout_d = mem_q[rd_ptr_q];
              pop_s    = 1'b1;
            end
          end
          OFF_STATUS: begin
            s_dout_d[3:0] = {udf_q, ovf_q, full_s, empty_s};
          end
          OFF_COUNT: begin
            s_dout_d[PTR_W:0] = count_q;
          end
          OFF_THRESH: begin
            s_dout_d[PTR_W:0] = thresh_q;
          end
          default: begin
            s_dout_d = WORD_ZERO;
          end
        endcase
      end
    end else begin
      s_dout_d = s_dout_q;
    end

    // Only one access per cycle, so at most one of these is set.
    if (flush_s) begin
      rd_ptr_d = PTR_ZERO;
      wr_ptr_d = PTR_ZERO;
      count_d  = CNT_ZERO;
    end else if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      count_d  = count_q + CNT_ONE;
    end else if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d  = count_q - CNT_ONE;
    end else begin
      count_d  = count_q;
    end
  end

  // FIFO occupancy state machine: next state from push/pop/flush.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (push_s) begin
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ACTIVE: begin
        if (flush_s) begin
          state_d = ST_EMPTY;
        end else if (push_s && (count_q == CNT_LAST)) begin
          state_d = ST_FULL;
        end else if (pop_s && (count_q == CNT_ONE)) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_FULL: begin
        if (flush_s) begin
          state_d = ST_EMPTY;
        end else if (pop_s) begin
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Control/status register bank with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= PTR_ZERO;
      wr_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
      thresh_q <= CNT_ZERO;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      s_dout_q <= WORD_ZERO;
      state_q  <= ST_EMPTY;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      thresh_q <= thresh_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      s_dout_q <= s_dout_d;
      state_q  <= state_d;
    end
  end

  // Data storage: no reset, stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= s_din;
    end
  end

  assign s_dout = s_dout_q;
  // A zero threshold disables the interrupt; a threshold above DEPTH never fires.
  assign irq    = (count_q >= thresh_q) && (thresh_q != CNT_ZERO);

endmodule

// File: tb/tb_bus_fifo_slave.sv
// ---------------------------------------------------------------------------
// tb_bus_fifo_slave
//   Scoreboard bench: the driver updates a queue-based FIFO model on every
//   access and pushes expected read data; a monitor pops and compares one
//   cycle after each read, and checks irq against the model every cycle.
// ---------------------------------------------------------------------------
module tb_bus_fifo_slave;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          clk;
  logic          reset_n;
  logic          s_sel;
  logic          s_wr;
  logic [7:0]    s_address;
  logic [DW-1:0] s_din;
  logic [DW-1:0] s_dout;
  logic          irq;

  int n_vec = 0;
  int n_err = 0;

  // Reference model
  logic [DW-1:0] mq[$];
  logic [DW-1:0] expq[$];
  bit            m_ovf = 1'b0;
  bit            m_udf = 1'b0;
  int            m_thresh = 0;
  logic [DW-1:0] mon_exp;

  bus_fifo_slave #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_W(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_sel     (s_sel),
    .s_wr      (s_wr),
    .s_address (s_address),
    .s_din     (s_din),
    .s_dout    (s_dout),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_irq();
    return (m_thresh != 0) && (mq.size() >= m_thresh);
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    m_thresh = 0;
  endtask

  // Apply one access to the model; reads queue their expected data.
  task automatic model_apply(input bit wr, input logic [4:0] off, input logic [DW-1:0] din);
    logic [DW-1:0] r;
    r = '0;
    if (wr) begin
      case (off)
        5'd0: if (mq.size() < DEPTH) mq.push_back(din); else m_ovf = 1'b1;
        5'd3: begin
          if (din[0]) mq.delete();
          if (din[1]) begin m_ovf = 1'b0; m_udf = 1'b0; end
        end
        5'd4: m_thresh = int'(din[3:0]);
        default: ;
      endcase
    end else begin
      case (off)
        5'd0: if (mq.size() > 0) r = mq.pop_front(); else m_udf = 1'b1;
        5'd1: r = {28'd0, m_udf, m_ovf, (mq.size() == DEPTH), (mq.size() == 0)};
        5'd2: r = DW'(mq.size());
        5'd4: r = DW'(m_thresh);
        default: r = '0;
      endcase
      expq.push_back(r);
    end
  endtask

  task automatic access(input bit wr, input logic [4:0] off, input logic [DW-1:0] din);
    @(negedge clk);
    s_sel     = 1'b1;
    s_wr      = wr;
    s_address = {3'($urandom_range(0, 7)), off};
    s_din     = din;
    @(posedge clk);
    model_apply(wr, off, din);
  endtask

  // Deselected cycles with junk on the other bus lines.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_sel     = 1'b0;
      s_wr      = 1'($urandom_range(0, 1));
      s_address = 8'($urandom);
      s_din     = $urandom;
    end
  endtask

  // Monitor: read data appears one cycle after each read access.
  always @(posedge clk) begin
    if (reset_n && s_sel && !s_wr) begin
      #1;
      if (expq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rdata: read with no expected entry, got %h", s_dout);
      end else begin
        mon_exp = expq.pop_front();
        check("rdata", s_dout, mon_exp);
      end
    end
  end

  // Monitor: irq tracks the model's fill level vs threshold.
  always @(negedge clk) begin
    check("irq", {31'd0, irq}, {31'd0, model_irq()});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    reset_n   = 1'b0;
    s_sel     = 1'b0;
    s_wr      = 1'b0;
    s_address = 8'h00;
    s_din     = 32'h0;
    #12;
    reset_n = 1'b1;
    #1;
    check("reset_dout", s_dout, 32'h0);

    // 1: reset state
    access(1'b0, 5'd1, 32'h0);
    access(1'b0, 5'd2, 32'h0);

    // 2: basic push/pop order with back-to-back reads
    access(1'b1, 5'd0, 32'h11);
    access(1'b1, 5'd0, 32'h22);
    access(1'b1, 5'd0, 32'h33);
    access(1'b0, 5'd2, 32'h0);
    for (int i = 0; i < 3; i++) access(1'b0, 5'd0, 32'h0);
    access(1'b0, 5'd2, 32'h0);

    // 3: overflow, ninth word dropped
    for (int i = 1; i <= 9; i++) access(1'b1, 5'd0, 32'h1000_0000 + 32'(i));
    access(1'b0, 5'd2, 32'h0);
    access(1'b0, 5'd1, 32'h0);
    for (int i = 0; i < 8; i++) access(1'b0, 5'd0, 32'h0);
    access(1'b1, 5'd3, 32'h2);

    // 4: underflow then sticky clear
    access(1'b0, 5'd0, 32'h0);
    access(1'b0, 5'd1, 32'h0);
    access(1'b1, 5'd3, 32'h2);
    access(1'b0, 5'd1, 32'h0);

    // 5: threshold irq and flush
    access(1'b1, 5'd4, 32'h3);
    access(1'b1, 5'd0, 32'hA1);
    access(1'b1, 5'd0, 32'hA2);
    idle(1);
    access(1'b1, 5'd0, 32'hA3);
    idle(1);
    access(1'b1, 5'd3, 32'h1);
    access(1'b0, 5'd2, 32'h0);
    access(1'b0, 5'd4, 32'h0);
    access(1'b0, 5'd3, 32'h0);

    // 6: pointer wrap
    for (int i = 0; i < 6; i++) access(1'b1, 5'd0, $urandom);
    for (int i = 0; i < 6; i++) access(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 5; i++) access(1'b1, 5'd0, $urandom);
    for (int i = 0; i < 5; i++) access(1'b0, 5'd0, 32'h0);

    // 6b: reset mid-operation with irq asserted and s_dout non-zero
    access(1'b1, 5'd4, 32'h1);
    access(1'b1, 5'd0, 32'hBEEF_0001);
    access(1'b1, 5'd0, 32'hBEEF_0002);
    idle(2);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_dout", s_dout, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    access(1'b0, 5'd2, 32'h0);
    access(1'b0, 5'd1, 32'h0);
    access(1'b0, 5'd0, 32'h0);
    access(1'b1, 5'd3, 32'h2);

    // Random traffic
    for (int k = 0; k < 800; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 38)      access(1'b1, 5'd0, $urandom);
      else if (r < 68) access(1'b0, 5'd0, 32'h0);
      else if (r < 74) access(1'b0, 5'd1, 32'h0);
      else if (r < 79) access(1'b0, 5'd2, 32'h0);
      else if (r < 83) access(1'b1, 5'd4, $urandom);
      else if (r < 86) access(1'b0, 5'd4, 32'h0);
      else if (r < 88) access(1'b1, 5'd3, $urandom);
      else if (r < 91) access(1'($urandom_range(0, 1)), 5'($urandom_range(5, 31)), $urandom);
      else             idle(int'($urandom_range(1, 2)));
    end

    idle(3);
    check("drain", 32'(expq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
